snake_body: RTL and testbench

SNAKE_BODY -- requirements
Module: snake_body

---
 rtl/snake_body.sv | 107 ++++++++++
 tb/tb_snake_body.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/snake_body.sv
// Snake body tracker: ring buffer of segment coordinates, occupancy bitmap for
// the display query port, growth handling and self-collision lock.
module snake_body #(
  parameter int unsigned WIDTH   = 16,
  parameter int unsigned HEIGHT  = 8,
  parameter int unsigned MAX_LEN = 32
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       step,
  input  logic [3:0] head_x,
  input  logic [3:0] head_y,
  input  logic       grow,
  input  logic [3:0] qx,
  input  logic [3:0] qy,
  output logic       occupied,
  output logic [5:0] length,
  output logic [3:0] tail_x,
  output logic [3:0] tail_y,
  output logic       lock
);

  localparam int unsigned CELLS = WIDTH * HEIGHT;
  localparam int unsigned CW    = $clog2(CELLS);
  localparam int unsigned PW    = $clog2(MAX_LEN);

  logic [3:0]       buf_x [MAX_LEN];
  logic [3:0]       buf_y [MAX_LEN];
  logic [PW-1:0]    head_ptr, tail_ptr;
  logic [PW-1:0]    head_next_ptr, tail_next_ptr;
  logic [CELLS-1:0] bitmap, bitmap_next;
  logic             grow_pending;

  logic             head_valid, query_valid;
  logic             accept, growing, vacating, collide;
  logic [CW-1:0]    head_cell, tail_cell, query_cell;
  logic [3:0]       next_tail_x, next_tail_y;

  always_comb begin
    head_valid    = (32'(head_x) < WIDTH) && (32'(head_y) < HEIGHT);
    query_valid   = (32'(qx) < WIDTH) && (32'(qy) < HEIGHT);
    head_cell     = CW'(32'(head_y) * WIDTH + 32'(head_x));
    tail_cell     = CW'(32'(tail_y) * WIDTH + 32'(tail_x));
    query_cell    = CW'(32'(qy) * WIDTH + 32'(qx));
    head_next_ptr = head_ptr + PW'(1);
    tail_next_ptr = tail_ptr + PW'(1);

    accept   = step && !lock && head_valid;
    growing  = (grow_pending || grow) && (32'(length) < MAX_LEN);
    vacating = !growing && (head_cell == tail_cell);
    collide  = bitmap[head_cell] && !vacating;

    // With a single segment the advancing tail lands on the slot being written now
    if (tail_next_ptr == head_next_ptr) begin
      next_tail_x = head_x;
      next_tail_y = head_y;
    end else begin
      next_tail_x = buf_x[tail_next_ptr];
      next_tail_y = buf_y[tail_next_ptr];
    end

    // Tail clear first, head set second, so the head wins on a shared cell
    bitmap_next = bitmap;
    if (!growing) bitmap_next[tail_cell] = 1'b0;
    bitmap_next[head_cell] = 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < MAX_LEN; i++) begin
        buf_x[i] <= '0;
        buf_y[i] <= '0;
      end
      head_ptr     <= '0;
      tail_ptr     <= '0;
      bitmap       <= CELLS'(1);
      grow_pending <= 1'b0;
      lock         <= 1'b0;
      occupied     <= 1'b0;
      length       <= 6'd1;
      tail_x       <= '0;
      tail_y       <= '0;
    end else begin
      occupied <= query_valid && bitmap[query_cell];
      if (accept && collide) begin
        lock <= 1'b1;
        if (grow) grow_pending <= 1'b1;
      end else if (accept) begin
        buf_x[head_next_ptr] <= head_x;
        buf_y[head_next_ptr] <= head_y;
        head_ptr             <= head_next_ptr;
        bitmap               <= bitmap_next;
        grow_pending         <= 1'b0;
        if (growing) begin
          length <= length + 6'd1;
        end else begin
          tail_ptr <= tail_next_ptr;
          tail_x   <= next_tail_x;
          tail_y   <= next_tail_y;
        end
      end else if (grow) begin
        grow_pending <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_snake_body.sv
// Bench for snake_body: queue-based body model checked every cycle, directed
// scenarios with literal expectations, then a randomized walk.
module tb_snake_body;

  logic       clk = 1'b0;
  logic       reset, step, grow;
  logic [3:0] head_x, head_y, qx, qy;
  logic       occupied;
  logic [5:0] length;
  logic [3:0] tail_x, tail_y;
  logic       lock;

  int errors = 0;
  int checks = 0;

  // Model: body as a queue of cells, oldest first
  int m_x[$];
  int m_y[$];
  bit m_lock, m_pend;

  snake_body #(.WIDTH(16), .HEIGHT(8), .MAX_LEN(32)) dut (
    .clk(clk), .reset(reset), .step(step), .head_x(head_x), .head_y(head_y),
    .grow(grow), .qx(qx), .qy(qy), .occupied(occupied), .length(length),
    .tail_x(tail_x), .tail_y(tail_y), .lock(lock)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic bit in_body(input int x, input int y);
    foreach (m_x[i]) if (m_x[i] == x && m_y[i] == y) return 1'b1;
    return 1'b0;
  endfunction

  function automatic void model_reset();
    m_x = {0};
    m_y = {0};
    m_lock = 1'b0;
    m_pend = 1'b0;
  endfunction

  function automatic void model_step(input bit s, input int hx, input int hy, input bit g);
    bit acc, growing, hit;
    acc = s && !m_lock && hx < 16 && hy < 8;
    if (!acc) begin
      if (g) m_pend = 1'b1;
      return;
    end
    growing = (m_pend || g) && m_x.size() < 32;
    hit = in_body(hx, hy) && !(!growing && m_x[0] == hx && m_y[0] == hy);
    if (hit) begin
      m_lock = 1'b1;
      if (g) m_pend = 1'b1;
    end else begin
      m_x.push_back(hx);
      m_y.push_back(hy);
      if (!growing) begin
        void'(m_x.pop_front());
        void'(m_y.pop_front());
      end
      m_pend = 1'b0;
    end
  endfunction

  task automatic compare_all(input bit exp_occ);
    chk("length", length, m_x.size());
    chk("tail_x", tail_x, m_x[0]);
    chk("tail_y", tail_y, m_y[0]);
    chk("lock", lock, m_lock);
    chk("occupied", occupied, exp_occ);
  endtask

  // One clock: drive inputs (called just after a falling edge), check after the rising edge
  task automatic cycle(input bit s, input int hx, input int hy, input bit g,
                       input int x, input int y);
    bit exp_occ;
    step = s; head_x = 4'(hx); head_y = 4'(hy); grow = g; qx = 4'(x); qy = 4'(y);
    exp_occ = (x < 16 && y < 8) && in_body(x, y);
    @(posedge clk);
    model_step(s, hx, hy, g);
    #1;
    compare_all(exp_occ);
    @(negedge clk);
  endtask

  task automatic do_reset(input bit s, input bit g);
    step = s; grow = g; head_x = 4'd1; head_y = 4'd0;
    reset = 1'b1;
    #1;
    chk("rst_length", length, 1);
    chk("rst_tail_x", tail_x, 0);
    chk("rst_tail_y", tail_y, 0);
    chk("rst_lock", lock, 0);
    chk("rst_occupied", occupied, 0);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    step = 1'b0; grow = 1'b0;
    model_reset();
  endtask

  initial begin
    int hx, hy, r, locked_cycles;
    reset = 1'b0; step = 1'b0; grow = 1'b0;
    head_x = '0; head_y = '0; qx = '0; qy = '0;
    @(negedge clk);
    do_reset(1'b0, 1'b0);

    // Two plain steps from the reset segment
    cycle(1, 1, 0, 0, 0, 0);
    cycle(1, 2, 0, 0, 0, 0);
    cycle(0, 0, 0, 0, 0, 0);
    chk("r33_occ00", occupied, 0);
    cycle(0, 0, 0, 0, 2, 0);
    chk("r33_occ20", occupied, 1);
    chk("r33_len", length, 1);
    chk("r33_tail_x", tail_x, 2);

    // Grow pulses ahead of steps
    do_reset(1'b0, 1'b0);
    cycle(0, 0, 0, 1, 0, 0);
    cycle(1, 1, 0, 0, 0, 0);
    cycle(0, 0, 0, 1, 0, 0);
    cycle(1, 2, 0, 0, 0, 0);
    chk("r34_len", length, 3);
    chk("r34_tail_x", tail_x, 0);
    for (int i = 0; i < 3; i++) begin
      cycle(0, 0, 0, 0, i, 0);
      chk("r34_occ", occupied, 1);
    end

    // Head onto vacating tail: allowed when not growing
    do_reset(1'b0, 1'b0);
    cycle(1, 1, 0, 1, 0, 0);
    cycle(1, 1, 1, 1, 0, 0);
    cycle(1, 0, 1, 1, 0, 0);
    chk("r35_len4", length, 4);
    cycle(1, 0, 0, 0, 0, 0);
    chk("r35_nolock", lock, 0);
    chk("r35_tail_x", tail_x, 1);
    chk("r35_tail_y", tail_y, 0);

    // Same move while growing collides
    do_reset(1'b0, 1'b0);
    cycle(1, 1, 0, 1, 0, 0);
    cycle(1, 1, 1, 1, 0, 0);
    cycle(1, 0, 1, 1, 0, 0);
    cycle(1, 0, 0, 1, 0, 0);
    chk("r35_lock", lock, 1);
    chk("r35_len_hold", length, 4);

    // Locked: steps ignored, grow still recorded until reset
    cycle(1, 2, 2, 0, 0, 0);
    cycle(1, 3, 2, 1, 2, 2);
    cycle(1, 4, 2, 0, 0, 0);
    chk("r36_len", length, 4);
    chk("r36_tail_x", tail_x, 0);
    chk("r36_occ00", occupied, 1);
    do_reset(1'b1, 1'b1);
    chk("r36_unlock", lock, 0);
    chk("r36_len1", length, 1);
    // Pending grow must have been wiped by reset
    cycle(1, 1, 0, 0, 0, 0);
    chk("r32_no_grow", length, 1);

    // Out-of-range heads and query
    do_reset(1'b0, 1'b0);
    cycle(1, 3, 8, 0, 15, 8);
    chk("r37_occ_oob", occupied, 0);
    cycle(1, 0, 15, 1, 0, 0);
    cycle(0, 0, 0, 0, 0, 0);
    chk("r37_len", length, 1);
    chk("r37_tail_y", tail_y, 0);

    // Saturating growth with pointer wrap
    do_reset(1'b0, 1'b0);
    for (int k = 1; k <= 40; k++) cycle(1, k % 16, k / 16, 1, 0, 0);
    chk("r38_len", length, 32);
    chk("r38_tail_x", tail_x, 9);
    chk("r38_tail_y", tail_y, 0);

    // Randomized walk
    do_reset(1'b0, 1'b0);
    locked_cycles = 0;
    for (int n = 0; n < 4000; n++) begin
      r = $urandom_range(0, 99);
      hx = m_x[m_x.size() - 1];
      hy = m_y[m_y.size() - 1];
      case ($urandom_range(0, 3))
        0: hx = (hx + 1) % 16;
        1: hx = (hx + 15) % 16;
        2: hy = (hy + 1) % 16;
        default: hy = (hy + 15) % 16;
      endcase
      if (r < 8) begin
        hx = $urandom_range(0, 15);
        hy = $urandom_range(0, 9);
      end
      if (m_lock) locked_cycles++;
      if (locked_cycles > 6 || r == 99) begin
        do_reset(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        locked_cycles = 0;
      end else begin
        cycle(r < 75, hx, hy, $urandom_range(0, 99) < 20,
              $urandom_range(0, 15), $urandom_range(0, 9));
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
